// File: rtl/cholesky_5_reconstruct_if.sv
// Request/response bundle for cholesky_5_reconstruct: packed L in, packed A out.
interface cholesky_5_reconstruct_if #(
    parameter int DATA_WIDTH = 32
);
    logic [15*DATA_WIDTH-1:0] L;
    logic                     L_valid;
    logic [15*DATA_WIDTH-1:0] A;
    logic                     A_valid;
    logic                     busy;

    modport master (output L, L_valid, input  A, A_valid, busy);
    modport slave  (input  L, L_valid, output A, A_valid, busy);
endinterface

// File: rtl/cholesky_5_reconstruct.sv
// Rebuilds the packed lower triangle of A = L*L^T from a packed 5x5 factor L
// using one shared signed MAC, one term per enabled CALC edge (35 per matrix).
module cholesky_5_reconstruct #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                    clk,
    input  logic                    clk_en,
    input  logic                    rst,
    cholesky_5_reconstruct_if.slave bus
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic {IDLE, CALC} state_t;
    state_t state_q, state_d;

    logic [14:0][DW-1:0]    l_q, a_q;
    logic [2:0]             row_q, col_q, term_q;
    logic signed [2*DW-1:0] acc_q, ma, mb, prod, sum;
    logic [DW-1:0]          word;
    logic [3:0]             ia, ib, iw;
    logic                   entry_last, mat_last;
    logic                   a_valid_q, busy_q;

    // Packed position of element (r,c), r>=c, in the LSB-first triangle layout.
    function automatic logic [3:0] tri_idx(input logic [2:0] r, input logic [2:0] c);
        logic [3:0] base;
        case (r)
            3'd0:    base = 4'd0;
            3'd1:    base = 4'd1;
            3'd2:    base = 4'd3;
            3'd3:    base = 4'd6;
            default: base = 4'd10;
        endcase
        return base + {1'b0, c};
    endfunction

    assign ia   = tri_idx(row_q, term_q);
    assign ib   = tri_idx(col_q, term_q);
    assign iw   = tri_idx(row_q, col_q);
    assign ma   = {{DW{l_q[ia][DW-1]}}, l_q[ia]};
    assign mb   = {{DW{l_q[ib][DW-1]}}, l_q[ib]};
    assign prod = ma * mb;
    assign sum  = acc_q + prod;
    // Single truncation per entry, after full-precision accumulation.
    assign word = DW'(sum >>> FRAC_BITS);

    assign entry_last = (term_q == col_q);
    assign mat_last   = entry_last && (row_q == 3'd4) && (col_q == 3'd4);

    always_ff @(posedge clk) begin
        if (rst)         state_q <= IDLE;
        else if (clk_en) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.L_valid) state_d = CALC;
            CALC:    if (mat_last)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_q       <= '0;
            a_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            term_q    <= '0;
            acc_q     <= '0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (clk_en) begin
            a_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.L_valid) begin
                    l_q    <= bus.L;
                    row_q  <= '0;
                    col_q  <= '0;
                    term_q <= '0;
                    acc_q  <= '0;
                    busy_q <= 1'b1;
                end
                CALC: if (entry_last) begin
                    a_q[iw] <= word;
                    acc_q   <= '0;
                    term_q  <= '0;
                    if (col_q == row_q) begin
                        row_q <= row_q + 3'd1;
                        col_q <= '0;
                    end else begin
                        col_q <= col_q + 3'd1;
                    end
                    if (mat_last) begin
                        a_valid_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end else begin
                    acc_q  <= sum;
                    term_q <= term_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.A       = a_q;
    assign bus.A_valid = a_valid_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_cholesky_5_reconstruct.sv
// Scoreboard bench for cholesky_5_reconstruct: expected A and arrival cycle are
// queued at issue time; a negedge monitor pops and compares on every A_valid.
module tb_cholesky_5_reconstruct;
    logic clk, clk_en, rst;
    int   cyc = 0;
    int   n_checks = 0, n_fail = 0;
    int   n_pushed = 0, n_pulses = 0;
    int   win_lo = 1000000, win_hi = 0, busy_low = 0;

    typedef struct {
        logic [479:0] a;
        int           due;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    cholesky_5_reconstruct_if #(.DATA_WIDTH(32)) bus();

    cholesky_5_reconstruct #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
        .clk    (clk),
        .clk_en (clk_en),
        .rst    (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    // A = L*L^T straight from the matrix definition, 64-bit sums, floor shift.
    function automatic logic [479:0] ref_model(input logic [479:0] l);
        logic signed [31:0] m[5][5];
        logic [479:0] r;
        longint s;
        int p;
        r = '0;
        p = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j <= i; j++) begin
                m[i][j] = l[p*32 +: 32];
                p++;
            end
        p = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j <= i; j++) begin
                s = 0;
                for (int k = 0; k <= j; k++) s += longint'(m[i][k]) * longint'(m[j][k]);
                r[p*32 +: 32] = 32'(s >>> 16);
                p++;
            end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [479:0] act, input logic [479:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= win_lo && cyc <= win_hi && !bus.busy) busy_low++;
        if (!rst && bus.A_valid) begin
            n_pulses++;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_A_valid at cyc=%0d", cyc);
            end else begin
                mon_e = q.pop_front();
                if (bus.A !== mon_e.a) begin
                    n_fail++;
                    $display("FAIL A_data: got %h expected %h", bus.A, mon_e.a);
                end
                n_checks++;
                if (cyc != mon_e.due) begin
                    n_fail++;
                    $display("FAIL A_valid_cycle: got %0d expected %0d", cyc, mon_e.due);
                end
            end
            n_checks++;
            if (bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_at_A_valid: got %b expected 0", bus.busy);
            end
        end
    end

    // Presents L for one edge; acceptance is the next edge, result visible 35 cycles later.
    task automatic issue(input logic [479:0] l, input logic [479:0] exp, input bit push, input int stall);
        @(posedge clk); #1;
        bus.L = l;
        bus.L_valid = 1'b1;
        if (push) begin
            q.push_back('{a: exp, due: cyc + 1 + 35 + stall});
            n_pushed++;
        end
        @(posedge clk); #1;
        bus.L_valid = 1'b0;
        for (int w = 0; w < 15; w++) bus.L[w*32 +: 32] = $urandom();
    endtask

    task automatic wait_idle();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    logic [479:0] l, e, l2;

    initial begin
        rst = 1'b1; clk_en = 1'b1; bus.L = '0; bus.L_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_A", bus.A, '0);
        chk("reset_A_valid", {479'd0, bus.A_valid}, '0);
        chk("reset_busy", {479'd0, bus.busy}, '0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed: small positive factor
        l = '0; l[0 +: 32] = 32'h0002_0000; l[32 +: 32] = 32'h0001_0000; l[64 +: 32] = 32'h0003_0000;
        e = '0; e[0 +: 32] = 32'h0004_0000; e[32 +: 32] = 32'h0002_0000; e[64 +: 32] = 32'h000A_0000;
        issue(l, e, 1'b1, 0); wait_idle();

        // Signs
        l = '0; l[0 +: 32] = 32'h0001_0000; l[32 +: 32] = 32'hFFFF_0000; l[64 +: 32] = 32'h0000_8000;
        e = '0; e[0 +: 32] = 32'h0001_0000; e[32 +: 32] = 32'hFFFF_0000; e[64 +: 32] = 32'h0001_4000;
        issue(l, e, 1'b1, 0); wait_idle();

        // Floor of a tiny negative product
        l = '0; l[0 +: 32] = 32'h0000_0001; l[32 +: 32] = 32'hFFFF_FFFF;
        e = '0; e[32 +: 32] = 32'hFFFF_FFFF;
        issue(l, e, 1'b1, 0); wait_idle();

        // Full-precision accumulation on A_55
        l = '0; for (int k = 10; k < 15; k++) l[k*32 +: 32] = 32'h0000_0100;
        e = '0; e[14*32 +: 32] = 32'h0000_0005;
        issue(l, e, 1'b1, 0); wait_idle();
        l = '0; for (int k = 10; k < 15; k++) l[k*32 +: 32] = 32'h0000_0080;
        e = '0; e[14*32 +: 32] = 32'h0000_0001;
        issue(l, e, 1'b1, 0); wait_idle();

        // Random factors vs reference model
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 15; w++)
                l[w*32 +: 32] = (r < 3) ? 32'($signed($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000) : $urandom();
            issue(l, ref_model(l), 1'b1, 0); wait_idle();
        end

        // clk_en low for 7 edges mid-CALC
        l = '0; l[0 +: 32] = 32'h0002_0000; l[32 +: 32] = 32'h0001_0000; l[64 +: 32] = 32'h0003_0000;
        e = '0; e[0 +: 32] = 32'h0004_0000; e[32 +: 32] = 32'h0002_0000; e[64 +: 32] = 32'h000A_0000;
        issue(l, e, 1'b1, 7);
        repeat (5) @(posedge clk); #1 clk_en = 1'b0;
        repeat (7) @(posedge clk); #1 clk_en = 1'b1;
        wait_idle();

        // L_valid held 100 cycles; L changes while busy, picked up only at the third acceptance
        for (int w = 0; w < 15; w++) begin
            l[w*32 +: 32]  = $urandom();
            l2[w*32 +: 32] = $urandom();
        end
        @(posedge clk); #1;
        bus.L = l; bus.L_valid = 1'b1;
        win_lo = cyc + 1; win_hi = cyc + 1 + 107; busy_low = 0;
        q.push_back('{a: ref_model(l),  due: cyc + 1 + 35});
        q.push_back('{a: ref_model(l),  due: cyc + 1 + 71});
        q.push_back('{a: ref_model(l2), due: cyc + 1 + 107});
        n_pushed += 3;
        repeat (50) @(posedge clk); #1 bus.L = l2;
        repeat (50) @(posedge clk); #1 bus.L_valid = 1'b0;
        wait_idle();
        win_lo = 1000000;
        chk("busy_low_cycles", 480'(busy_low), 480'd3);

        // Reset at the 10th CALC edge aborts
        for (int w = 0; w < 15; w++) l[w*32 +: 32] = $urandom();
        issue(l, '0, 1'b0, 0);
        repeat (9) @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_A", bus.A, '0);
        chk("abort_busy", {479'd0, bus.busy}, '0);
        repeat (60) @(posedge clk);
        issue(l, ref_model(l), 1'b1, 0); wait_idle();

        chk("pulse_count", 480'(n_pulses), 480'(n_pushed));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
